register_bank: RTL

Parametrised multi-port register bank for the pipelined MIPS core, replacing the fixed 32×32, two-read/one-write register file. Configurable data width, register count, read-port count and write-port count. Adds a per-register pending-write scoreboard (saturating counters) so decode can detect RAW hazards, plus optional same-cycle write-to-read bypass. Sits between decode (read/reserve) and writeback (write/release).

---
 rtl/register_bank_pkg.sv | 21 ++
 rtl/register_bank_pend.sv | 45 ++++
 rtl/register_bank.sv | 111 +++++++++++
 3 files changed

// File: rtl/register_bank_pkg.sv
// Shared types for the register bank: default core-sized index/word/pending
// types, the register-zero index, and the width helper for release counts.
package register_bank_pkg;

    localparam int CPU_DW     = 32;
    localparam int CPU_NREGS  = 32;
    localparam int CPU_AW     = $clog2(CPU_NREGS);
    localparam int CPU_PEND_W = 2;

    typedef logic [CPU_DW-1:0]     word_t;
    typedef logic [CPU_AW-1:0]     regidx_t;
    typedef logic [CPU_PEND_W-1:0] pend_t;

    localparam regidx_t REG_ZERO = '0;

    // Bits needed to hold a release count of 0..n (n simultaneous write ports).
    function automatic int dec_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/register_bank_pend.sv
// Single-register pending-write counter: saturating up/down counter with one
// increment (accepted reservation) and 0..NWR decrements (write releases) per
// cycle, combined to a net value clamped to [0, 2^PEND_W-1]. flush wins.
module register_bank_pend
    import register_bank_pkg::*;
#(
    parameter int PEND_W = 2,
    parameter int NWR    = 1,
    localparam int CW    = dec_width(NWR)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic [CW-1:0]     dec,
    input  logic              flush,
    output logic [PEND_W-1:0] count
);

    // Signed headroom so the net value can go below zero or above max before clamping.
    localparam int SW = PEND_W + CW + 2;
    localparam logic signed [SW-1:0] MAX_S = SW'((1 << PEND_W) - 1);

    logic signed [SW-1:0] net;

    // Net of this cycle's reservation and releases before clamping.
    always_comb begin
        net = $signed(SW'(count)) + $signed(SW'(inc)) - $signed(SW'(dec));
    end

    // Counter update: flush clears, otherwise clamp the net value into range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (net < 0) begin
            count <= '0;
        end else if (net > MAX_S) begin
            count <= '1;
        end else begin
            count <= net[PEND_W-1:0];
        end
    end

endmodule

// File: rtl/register_bank.sv
// Parametrised multi-port register bank with per-register pending-write
// scoreboard for RAW hazard detection. Register 0 is hard-wired to zero and
// never pending. Optional same-cycle write-to-read forwarding is compiled in
// when REGISTER_BANK_BYPASS_EN is defined; by default rdat is the stored value.
module register_bank
    import register_bank_pkg::*;
#(
    parameter int DW     = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int PEND_W = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [NRD*AW-1:0] rsel,
    output logic [NRD*DW-1:0] rdat,
    output logic [NRD-1:0]    rbusy,
    input  logic [NWR-1:0]    wen,
    input  logic [NWR*AW-1:0] wsel,
    input  logic [NWR*DW-1:0] wdat,
    input  logic              rsv_en,
    input  logic [AW-1:0]     rsv_sel,
    output logic              rsv_ok,
    input  logic              flush
);

    localparam int CW = dec_width(NWR);
    localparam logic [AW-1:0]     ZERO_IDX = AW'(REG_ZERO);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [DW-1:0]     regs [NREGS];
    logic [PEND_W-1:0] pend [NREGS];

    // A reservation is accepted unless the target counter is already saturated.
    assign rsv_ok = (rsv_sel == ZERO_IDX) || (pend[rsv_sel] != PEND_MAX);

    genvar r;
    generate
        for (r = 0; r < NREGS; r++) begin : g_reg
            if (r == 0) begin : g_zero
                assign regs[r] = '0;
                assign pend[r] = '0;
            end else begin : g_live
                logic          inc;
                logic [CW-1:0] dec;

                assign inc = rsv_en && rsv_ok && (rsv_sel == AW'(r));

                // Count the write ports releasing this register this cycle.
                always_comb begin
                    dec = '0;
                    for (int p = 0; p < NWR; p++) begin
                        if (wen[p] && (wsel[p*AW +: AW] == AW'(r))) begin
                            dec = dec + CW'(1);
                        end
                    end
                end

                // Data storage; later ports overwrite earlier ones on conflict.
                always_ff @(posedge CLK or negedge nRST) begin
                    if (!nRST) begin
                        regs[r] <= '0;
                    end else begin
                        for (int p = 0; p < NWR; p++) begin
                            if (wen[p] && (wsel[p*AW +: AW] == AW'(r))) begin
                                regs[r] <= wdat[p*DW +: DW];
                            end
                        end
                    end
                end

                register_bank_pend #(
                    .PEND_W (PEND_W),
                    .NWR    (NWR)
                ) u_pend (
                    .clk   (CLK),
                    .rst_n (nRST),
                    .inc   (inc),
                    .dec   (dec),
                    .flush (flush),
                    .count (pend[r])
                );
            end
        end
    endgenerate

    // Read ports: stored data (optionally forwarded) and registered busy flag.
    always_comb begin
        logic [AW-1:0] sel;
        rdat  = '0;
        rbusy = '0;
        sel   = '0;
        for (int i = 0; i < NRD; i++) begin
            sel = rsel[i*AW +: AW];
            rdat[i*DW +: DW] = regs[sel];
            rbusy[i] = (sel != ZERO_IDX) && (pend[sel] != '0);
`ifdef REGISTER_BANK_BYPASS_EN
            if (sel != ZERO_IDX) begin
                for (int p = 0; p < NWR; p++) begin
                    if (wen[p] && (wsel[p*AW +: AW] == sel)) begin
                        rdat[i*DW +: DW] = wdat[p*DW +: DW];
                    end
                end
            end
`endif
        end
    end

endmodule
